// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: drives an external 8-bit combinational ALU one byte per
// cycle (LSB first) to execute a word-wide request, chaining the carry between
// bytes and keeping a sticky carry so ADDC/SUBC requests chain across words.

`ifndef ADD_FN
`define ADD_FN  3'b001
`define ADDC_FN 3'b010
`define SUB_FN  3'b011
`define SUBC_FN 3'b100
`define AND_FN  3'b101
`define OR_FN   3'b110
`endif

module alu_word_sequencer #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_result,
    output logic                  rsp_c,
    output logic                  rsp_z,
    output logic                  rsp_n,
    output logic [7:0]            alu_in1,
    output logic [7:0]            alu_in2,
    output logic                  alu_c_in,
    output logic [2:0]            alu_opcode,
    input  logic [7:0]            alu_out,
    input  logic                  alu_c_out,
    input  logic                  alu_z_out,
    input  logic                  alu_n_out
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d;        // operand A, shifted right one byte per EXEC cycle
    logic [W-1:0]     b_q, b_d;        // operand B, shifted the same way
    logic [W-1:0]     result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             z_q, z_d;
    logic             chain_q, chain_d;
    logic             sticky_q, sticky_d;
    logic             c_q, c_d;
    logic             n_q, n_d;

    logic       is_arith;
    logic       is_legal;
    logic       first_byte;
    logic       last_byte;
    logic [7:0] res_byte;

    // Classify the latched opcode and locate the current byte within the word.
    always_comb begin
        is_arith   = (op_q == `ADD_FN) || (op_q == `ADDC_FN) ||
                     (op_q == `SUB_FN) || (op_q == `SUBC_FN);
        is_legal   = is_arith || (op_q == `AND_FN) || (op_q == `OR_FN);
        first_byte = (idx_q == '0);
        last_byte  = (idx_q == LAST_IDX);
        res_byte   = is_legal ? alu_out : 8'h00;
    end

    // Drive the ALU: operands are the low bytes of the shifting operand
    // registers; opcode and carry-in follow the byte position.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        alu_in1    = 8'h00;
        alu_in2    = 8'h00;
        alu_c_in   = 1'b0;
        alu_opcode = 3'b000;
        if (state_q == EXEC && is_legal) begin
            alu_in1 = a_q[7:0];
            alu_in2 = b_q[7:0];
            case (op_q)
                `ADD_FN: begin
                    alu_opcode = first_byte ? `ADD_FN : `ADDC_FN;
                    alu_c_in   = first_byte ? 1'b0 : chain_q;
                end
                `SUB_FN: begin
                    alu_opcode = first_byte ? `SUB_FN : `SUBC_FN;
                    alu_c_in   = first_byte ? 1'b0 : chain_q;
                end
                `ADDC_FN, `SUBC_FN: begin
                    alu_opcode = op_q;
                    alu_c_in   = first_byte ? sticky_q : chain_q;
                end
                default: begin
                    alu_opcode = op_q;
                    alu_c_in   = 1'b0;
                end
            endcase
        end
    end

    // Next-state logic: accept in IDLE, capture one byte per EXEC cycle,
    // hold the response in DONE until it is consumed.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        z_d      = z_q;
        chain_d  = chain_q;
        sticky_d = sticky_q;
        c_d      = c_q;
        n_d      = n_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = EXEC;
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    idx_d   = '0;
                    z_d     = 1'b1;
                    chain_d = 1'b0;
                end
            end
            EXEC: begin
                a_d      = a_q >> 8;
                b_d      = b_q >> 8;
                // New byte enters at the top; after NBYTES shifts byte 0 sits at the bottom.
                result_d = W'({res_byte, result_q} >> 8);
                z_d      = z_q & (is_legal ? alu_z_out : 1'b1);
                chain_d  = is_arith & alu_c_out;
                if (last_byte) begin
                    state_d = DONE;
                    c_d     = is_arith & alu_c_out;
                    n_d     = is_legal & alu_n_out;
                    if (is_arith) begin
                        sticky_d = alu_c_out;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            z_q      <= 1'b0;
            chain_q  <= 1'b0;
            sticky_q <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            z_q      <= z_d;
            chain_q  <= chain_d;
            sticky_q <= sticky_d;
            c_q      <= c_d;
            n_q      <= n_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign rsp_result = result_q;
    assign rsp_c      = c_q;
    assign rsp_z      = z_q;
    assign rsp_n      = n_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Testbench for alu_word_sequencer: models the 8-bit ALU the sequencer drives
// and checks every byte step and word response against a word-level model.

`ifndef ADD_FN
`define ADD_FN  3'b001
`define ADDC_FN 3'b010
`define SUB_FN  3'b011
`define SUBC_FN 3'b100
`define AND_FN  3'b101
`define OR_FN   3'b110
`endif

module tb_alu_word_sequencer;

    localparam int NBYTES = 2;
    localparam int W      = 8 * NBYTES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_c;
    logic          rsp_z;
    logic          rsp_n;
    logic [7:0]    alu_in1;
    logic [7:0]    alu_in2;
    logic          alu_c_in;
    logic [2:0]    alu_opcode;
    logic [7:0]    alu_out;
    logic          alu_c_out;
    logic          alu_z_out;
    logic          alu_n_out;
    logic [8:0]    alu_t;

    int checks   = 0;
    int failures = 0;
    logic sticky_m;   // model of the sticky carry

    always #5 clk = ~clk;

    alu_word_sequencer #(.NBYTES(NBYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_c      (rsp_c),
        .rsp_z      (rsp_z),
        .rsp_n      (rsp_n),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_c_in   (alu_c_in),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_c_out  (alu_c_out),
        .alu_z_out  (alu_z_out),
        .alu_n_out  (alu_n_out)
    );

    // Combinational 8-bit ALU; subtraction reports borrow on the carry output.
    always_comb begin
        case (alu_opcode)
            `ADD_FN:  alu_t = {1'b0, alu_in1} + {1'b0, alu_in2};
            `ADDC_FN: alu_t = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'h00, alu_c_in};
            `SUB_FN:  alu_t = {1'b0, alu_in1} - {1'b0, alu_in2};
            `SUBC_FN: alu_t = {1'b0, alu_in1} - {1'b0, alu_in2} - {8'h00, alu_c_in};
            `AND_FN:  alu_t = {1'b0, alu_in1 & alu_in2};
            `OR_FN:   alu_t = {1'b0, alu_in1 | alu_in2};
            default:  alu_t = 9'h000;
        endcase
        alu_out   = alu_t[7:0];
        alu_c_out = alu_t[8];
        alu_z_out = (alu_t[7:0] == 8'h00);
        alu_n_out = alu_t[7];
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic is_arith(input logic [2:0] op);
        return (op == `ADD_FN) || (op == `ADDC_FN) || (op == `SUB_FN) || (op == `SUBC_FN);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return is_arith(op) || (op == `AND_FN) || (op == `OR_FN);
    endfunction

    // Opcode the ALU should see on byte k.
    function automatic logic [2:0] exp_opc(input logic [2:0] op, input int k);
        case (op)
            `ADD_FN: return (k == 0) ? `ADD_FN : `ADDC_FN;
            `SUB_FN: return (k == 0) ? `SUB_FN : `SUBC_FN;
            `ADDC_FN, `SUBC_FN, `AND_FN, `OR_FN: return op;
            default: return 3'b000;
        endcase
    endfunction

    // Carry (or borrow) into byte k, from the low 8k bits of the operands.
    function automatic logic exp_cin(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input int k, input logic cin0);
        logic [W:0] m;
        logic [W:0] s;
        if (!is_arith(op)) return 1'b0;
        if (k == 0) return cin0;
        m = ({{W{1'b0}}, 1'b1} << (8 * k)) - 1;
        if (op == `ADD_FN || op == `ADDC_FN) begin
            s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, cin0};
            return s[8 * k];
        end
        return (({1'b0, a} & m) < (({1'b0, b} & m) + {{W{1'b0}}, cin0}));
    endfunction

    // Word-level reference: plain arithmetic over the whole word.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic z, output logic n);
        logic [W:0] t;
        logic       cin0;
        cin0 = (op == `ADDC_FN || op == `SUBC_FN) ? sticky_m : 1'b0;
        case (op)
            `ADD_FN, `ADDC_FN: t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin0};
            `SUB_FN, `SUBC_FN: t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin0};
            `AND_FN:           t = {1'b0, a & b};
            `OR_FN:            t = {1'b0, a | b};
            default:           t = '0;
        endcase
        r = t[W-1:0];
        c = is_arith(op) ? t[W] : 1'b0;
        z = (r == '0);
        n = r[W-1];
        if (is_arith(op)) sticky_m = c;
    endtask

    // One full request: accept, per-byte checks, response, optional stall, release.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall);
        logic [W-1:0] er;
        logic         ec, ez, en, cin0;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        cin0 = (op == `ADDC_FN || op == `SUBC_FN) ? sticky_m : 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            check("exec_opcode", alu_opcode, exp_opc(op, k));
            check("exec_c_in", alu_c_in, exp_cin(op, a, b, k, cin0));
            check("exec_in1", alu_in1, is_legal(op) ? 8'(a >> (8 * k)) : 8'h00);
            check("exec_in2", alu_in2, is_legal(op) ? 8'(b >> (8 * k)) : 8'h00);
            check("exec_rsp_valid", rsp_valid, 0);
            check("exec_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        model(op, a, b, er, ec, ez, en);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_result", rsp_result, er);
        check("rsp_c", rsp_c, ec);
        check("rsp_z", rsp_z, ez);
        check("rsp_n", rsp_n, en);
        check("done_req_ready", req_ready, 0);
        check("done_alu_opcode", alu_opcode, 0);
        for (int s = 0; s < stall; s++) begin
            req_valid = (s == 1);
            req_op    = `ADD_FN;
            @(posedge clk); #1;
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_result", rsp_result, er);
            check("stall_flags", {rsp_c, rsp_z, rsp_n}, {ec, ez, en});
            check("stall_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("release_rsp_valid", rsp_valid, 0);
        check("release_req_ready", req_ready, 1);
        check("release_alu_opcode", alu_opcode, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        sticky_m  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_flags", {rsp_c, rsp_z, rsp_n}, 3'b000);
        check("reset_alu", {alu_in1, alu_in2, alu_c_in, alu_opcode}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        do_op(`ADD_FN,  16'h00FF, 16'h0001, 0);
        do_op(`ADD_FN,  16'hFFFF, 16'h0001, 0);
        do_op(`ADDC_FN, 16'h0000, 16'h0000, 0);
        do_op(`ADD_FN,  16'hFFFF, 16'h0001, 0);   // sticky = 1
        do_op(`AND_FN,  16'hF0AA, 16'hAAF0, 0);
        do_op(`OR_FN,   16'hF0F0, 16'hAAAA, 0);
        do_op(`ADDC_FN, 16'h0000, 16'h0000, 0);   // sticky survives logic ops
        do_op(`SUB_FN,  16'h0100, 16'h0001, 0);
        do_op(`SUB_FN,  16'h1234, 16'h1234, 0);
        do_op(`SUB_FN,  16'h0000, 16'h0001, 0);   // borrow -> sticky = 1
        do_op(3'b000,   16'h1234, 16'h5678, 0);   // unsupported opcodes
        do_op(3'b111,   16'hFFFF, 16'hFFFF, 0);
        do_op(`SUBC_FN, 16'h0005, 16'h0002, 0);
        do_op(`ADD_FN,  16'h8000, 16'h0001, 5);   // backpressure

        // Asynchronous reset in the second EXEC cycle of an ADD.
        check("req_ready_pre_reset", req_ready, 1);
        req_valid = 1'b1;
        req_op    = `ADD_FN;
        req_a     = 16'hABCD;
        req_b     = 16'h1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midreset_rsp_valid", rsp_valid, 0);
        check("midreset_req_ready", req_ready, 1);
        check("midreset_rsp_result", rsp_result, 0);
        check("midreset_alu_opcode", alu_opcode, 0);
        #1;
        rst_n    = 1'b1;
        sticky_m = 1'b0;
        @(posedge clk); #1;
        do_op(`ADD_FN,  16'h1234, 16'h4321, 0);
        do_op(`ADDC_FN, 16'hFFFF, 16'h0000, 0);   // sticky must read 0 after reset

        // Randomized operations with random backpressure.
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
